// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared types for the pipeline control slice: FSM state
//                encoding, register index width and the stage control bundle.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

   localparam int c_reg_idx_w = 4;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   // Freeze/flush controls consumed by the stage registers
   typedef struct packed {
      logic freeze_pc;
      logic freeze_if_id;
      logic flush_if_id;
      logic flush_id_exe;
      logic freeze_id_exe;
      logic freeze_exe_mem;
      logic bubble_mem_wb;
   } ctrl_t;

   // True when an enabled producer writes register r
   function automatic logic reg_match(input logic en,
                                      input logic [c_reg_idx_w-1:0] dst,
                                      input logic [c_reg_idx_w-1:0] r);
      return en & (dst == r);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up counter that sticks at all-ones; synchronous clear,
//                asynchronous active-high reset.
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Increment until all-ones, then hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Pipeline freeze/flush control. Memory stall beats taken
//                branch beats data hazard. Keeps saturating stall/flush
//                statistics and a sticky memory timeout flag.
//                Build option: PIPE_FORWARDING_EN restricts hazards to
//                load-use on the EXE stage.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       src1,
   input  logic [3:0]       src2,
   input  logic             use_src1,
   input  logic             two_src,
   input  logic             exe_wb_en,
   input  logic             exe_mem_r_en,
   input  logic [3:0]       exe_dst,
   input  logic             mem_wb_en,
   input  logic [3:0]       mem_dst,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             freeze_pc,
   output logic             freeze_if_id,
   output logic             flush_if_id,
   output logic             flush_id_exe,
   output logic             freeze_id_exe,
   output logic             freeze_exe_mem,
   output logic             bubble_mem_wb,
   output logic             hazard,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int                c_wait_w  = $clog2(MEM_TIMEOUT + 1);
   localparam logic [c_wait_w-1:0] c_timeout = c_wait_w'(MEM_TIMEOUT);

   state_t              r_state;
   logic [c_wait_w-1:0] r_wait_cnt;
   logic [c_wait_w-1:0] w_wait_inc;
   logic                w_mem_stall;
   logic                w_match1;
   logic                w_match2;
   logic                w_hazard;
   logic                w_unused;
   ctrl_t               w_ctrl;

   assign w_mem_stall = mem_req & ~mem_ready;
   assign w_wait_inc  = r_wait_cnt + 1'b1;

`ifdef PIPE_FORWARDING_EN
   // Forwarding covers everything except a load still in EXE
   assign w_match1 = reg_match(exe_mem_r_en & exe_wb_en, exe_dst, src1);
   assign w_match2 = reg_match(exe_mem_r_en & exe_wb_en, exe_dst, src2);
   assign w_unused = mem_wb_en ^ (^mem_dst);
`else
   // Without forwarding any pending writer of a source must drain first
   assign w_match1 = reg_match(exe_wb_en, exe_dst, src1) | reg_match(mem_wb_en, mem_dst, src1);
   assign w_match2 = reg_match(exe_wb_en, exe_dst, src2) | reg_match(mem_wb_en, mem_dst, src2);
   assign w_unused = exe_mem_r_en;
`endif

   assign w_hazard = (use_src1 & w_match1) | (two_src & w_match2);

   // Prioritised control decode; everything is forced low while in reset
   always_comb begin
      w_ctrl = '0;
      if (!rst) begin
         if (w_mem_stall) begin
            w_ctrl.freeze_pc      = 1'b1;
            w_ctrl.freeze_if_id   = 1'b1;
            w_ctrl.freeze_id_exe  = 1'b1;
            w_ctrl.freeze_exe_mem = 1'b1;
            w_ctrl.bubble_mem_wb  = 1'b1;
         end else if (branch_taken) begin
            // ID instruction is killed, so its hazard no longer matters
            w_ctrl.flush_if_id  = 1'b1;
            w_ctrl.flush_id_exe = 1'b1;
         end else if (w_hazard) begin
            w_ctrl.freeze_pc    = 1'b1;
            w_ctrl.freeze_if_id = 1'b1;
            w_ctrl.flush_id_exe = 1'b1;
         end
      end
   end

   assign freeze_pc      = w_ctrl.freeze_pc;
   assign freeze_if_id   = w_ctrl.freeze_if_id;
   assign flush_if_id    = w_ctrl.flush_if_id;
   assign flush_id_exe   = w_ctrl.flush_id_exe;
   assign freeze_id_exe  = w_ctrl.freeze_id_exe;
   assign freeze_exe_mem = w_ctrl.freeze_exe_mem;
   assign bubble_mem_wb  = w_ctrl.bubble_mem_wb;
   assign hazard         = w_hazard & ~rst;

   // Memory wait FSM with wait-cycle counter and sticky timeout flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= RUN;
         r_wait_cnt  <= '0;
         mem_timeout <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               r_wait_cnt <= '0;
               if (w_mem_stall) begin
                  r_state <= MEM_WAIT;
               end
            end
            MEM_WAIT: begin
               if (mem_ready) begin
                  r_state    <= RUN;
                  r_wait_cnt <= '0;
               end else if (r_wait_cnt != c_timeout) begin
                  r_wait_cnt <= w_wait_inc;
                  if (w_wait_inc == c_timeout) begin
                     mem_timeout <= 1'b1;
                  end
               end
            end
            default: begin
               r_state    <= RUN;
               r_wait_cnt <= '0;
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (1'b0),
      .inc   (w_ctrl.freeze_pc),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (1'b0),
      .inc   (w_ctrl.flush_if_id),
      .count (flush_cnt)
   );

endmodule
`default_nettype wire
